// File: rtl/victim_cache_assoc_pkg.sv
// Shared types and sizing helpers for the fully-associative victim cache.
package victim_cache_assoc_pkg;

  // Tags are stored zero-extended to this width so one entry struct serves every parametrisation.
  localparam int unsigned MaxTagBits = 64;

  typedef enum logic [2:0] {
    StIdle,
    StHitResp,
    StFill,
    StFillResp,
    StWb,
    StInsert
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic                  dirty;
    logic [MaxTagBits-1:0] tag;
  } vc_entry_t;

  function automatic int unsigned tag_bits(int unsigned addr_bits, int unsigned offset_bits);
    return addr_bits - offset_bits;
  endfunction

  function automatic int unsigned age_bits(int unsigned entries);
    return (entries < 2) ? 1 : $clog2(entries);
  endfunction

endpackage

// File: rtl/victim_cache_assoc_lru.sv
// Age-counter LRU tracker: ages always form a permutation of 0..Entries-1, max age is LRU.
module vc_lru_tracker
  import victim_cache_assoc_pkg::*;
#(
  parameter int unsigned Entries = 8,
  localparam int unsigned AgeBits = age_bits(Entries)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            touch_i,
  input  logic [AgeBits-1:0]              touch_idx_i,
  input  logic                            demote_i,
  input  logic [AgeBits-1:0]              demote_idx_i,
  output logic [AgeBits-1:0]              lru_idx_o,
  output logic [Entries-1:0][AgeBits-1:0] ages_o
);

  logic [Entries-1:0][AgeBits-1:0] age_q, age_d;
  logic [AgeBits-1:0]              old_age;

  always_comb begin
    age_d   = age_q;
    old_age = '0;
    if (touch_i) begin
      old_age = age_q[touch_idx_i];
      for (int unsigned j = 0; j < Entries; j++) begin
        if (AgeBits'(j) == touch_idx_i) begin
          age_d[j] = '0;
        end else if (age_q[j] < old_age) begin
          age_d[j] = age_q[j] + 1'b1;
        end
      end
    end else if (demote_i) begin
      // Entries older than the demoted one shift down to keep the permutation intact.
      old_age = age_q[demote_idx_i];
      for (int unsigned j = 0; j < Entries; j++) begin
        if (AgeBits'(j) == demote_idx_i) begin
          age_d[j] = AgeBits'(Entries - 1);
        end else if (age_q[j] > old_age) begin
          age_d[j] = age_q[j] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    lru_idx_o = '0;
    for (int unsigned j = 0; j < Entries; j++) begin
      if (age_q[j] == AgeBits'(Entries - 1)) begin
        lru_idx_o = AgeBits'(j);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned j = 0; j < Entries; j++) begin
        age_q[j] <= AgeBits'(j);
      end
    end else begin
      age_q <= age_d;
    end
  end

  assign ages_o = age_q;

endmodule

// File: rtl/victim_cache_assoc.sv
// Fully-associative, line-granular victim cache with swap-on-hit and dirty write-back on eviction.
module victim_cache_assoc
  import victim_cache_assoc_pkg::*;
#(
  parameter int unsigned Entries    = 8,
  parameter int unsigned LineBits   = 256,
  parameter int unsigned AddrBits   = 32,
  parameter int unsigned OffsetBits = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic [AddrBits-1:0] mem_address_i,
  input  logic [LineBits-1:0] mem_wdata_i,
  input  logic                mem_wdirty_i,
  output logic [LineBits-1:0] mem_rdata_o,
  output logic                mem_rdirty_o,
  output logic                mem_resp_o,
  output logic                pmem_read_o,
  output logic                pmem_write_o,
  output logic [AddrBits-1:0] pmem_address_o,
  output logic [LineBits-1:0] pmem_wdata_o,
  input  logic [LineBits-1:0] pmem_rdata_i,
  input  logic                pmem_resp_i
);

  localparam int unsigned TagBits = tag_bits(AddrBits, OffsetBits);
  localparam int unsigned AgeBits = age_bits(Entries);

  state_t              state_q, state_d;
  logic [AgeBits-1:0]  sel_q, sel_d;
  logic                merge_q, merge_d;
  logic [LineBits-1:0] fill_q, fill_d;

  vc_entry_t           entry_q [Entries];
  logic [LineBits-1:0] data_q  [Entries];

  logic                entry_we;
  vc_entry_t           entry_wdata;
  logic                data_we;

  logic [TagBits-1:0]    req_tag;
  logic [MaxTagBits-1:0] req_tag_ext;
  logic                  hit, free;
  logic [AgeBits-1:0]    hit_idx, free_idx;

  logic                            touch, demote;
  logic [AgeBits-1:0]              lru_idx;
  logic [Entries-1:0][AgeBits-1:0] ages;

  logic unused_offset;
  assign unused_offset = ^mem_address_i[OffsetBits-1:0];

  assign req_tag     = mem_address_i[AddrBits-1:OffsetBits];
  assign req_tag_ext = MaxTagBits'(req_tag);

  always_comb begin
    hit      = 1'b0;
    free     = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int unsigned i = 0; i < Entries; i++) begin
      if (!entry_q[i].valid && !free) begin
        free     = 1'b1;
        free_idx = AgeBits'(i);
      end
      if (entry_q[i].valid && entry_q[i].tag == req_tag_ext) begin
        hit     = 1'b1;
        hit_idx = AgeBits'(i);
      end
    end
  end

  vc_lru_tracker #(
    .Entries (Entries)
  ) u_lru (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .touch_i      (touch),
    .touch_idx_i  (sel_q),
    .demote_i     (demote),
    .demote_idx_i (sel_q),
    .lru_idx_o    (lru_idx),
    .ages_o       (ages)
  );

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    merge_d        = merge_q;
    fill_d         = fill_q;
    entry_we       = 1'b0;
    entry_wdata    = entry_q[sel_q];
    data_we        = 1'b0;
    touch          = 1'b0;
    demote         = 1'b0;
    mem_resp_o     = 1'b0;
    mem_rdata_o    = '0;
    mem_rdirty_o   = 1'b0;
    pmem_read_o    = 1'b0;
    pmem_write_o   = 1'b0;
    pmem_address_o = '0;
    pmem_wdata_o   = '0;

    case (state_q)
      StIdle: begin
        if (mem_read_i) begin
          if (hit) begin
            sel_d   = hit_idx;
            state_d = StHitResp;
          end else begin
            state_d = StFill;
          end
        end else if (mem_write_i) begin
          merge_d = hit;
          if (hit) begin
            sel_d   = hit_idx;
            state_d = StInsert;
          end else if (free) begin
            sel_d   = free_idx;
            state_d = StInsert;
          end else begin
            sel_d   = lru_idx;
            state_d = entry_q[lru_idx].dirty ? StWb : StInsert;
          end
        end
      end
      StHitResp: begin
        mem_resp_o   = 1'b1;
        mem_rdata_o  = data_q[sel_q];
        mem_rdirty_o = entry_q[sel_q].dirty;
        entry_we     = 1'b1;
        entry_wdata  = '0;
        demote       = 1'b1;
        state_d      = StIdle;
      end
      StFill: begin
        pmem_read_o    = 1'b1;
        pmem_address_o = {req_tag, {OffsetBits{1'b0}}};
        if (pmem_resp_i) begin
          fill_d  = pmem_rdata_i;
          state_d = StFillResp;
        end
      end
      StFillResp: begin
        mem_resp_o  = 1'b1;
        mem_rdata_o = fill_q;
        state_d     = StIdle;
      end
      StWb: begin
        pmem_write_o   = 1'b1;
        pmem_address_o = {entry_q[sel_q].tag[TagBits-1:0], {OffsetBits{1'b0}}};
        pmem_wdata_o   = data_q[sel_q];
        if (pmem_resp_i) begin
          state_d = StInsert;
        end
      end
      StInsert: begin
        mem_resp_o        = 1'b1;
        entry_we          = 1'b1;
        entry_wdata.valid = 1'b1;
        entry_wdata.dirty = mem_wdirty_i | (merge_q & entry_q[sel_q].dirty);
        entry_wdata.tag   = req_tag_ext;
        data_we           = 1'b1;
        touch             = 1'b1;
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sel_q   <= '0;
      merge_q <= 1'b0;
      fill_q  <= '0;
      for (int unsigned i = 0; i < Entries; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      merge_q <= merge_d;
      fill_q  <= fill_d;
      if (entry_we) begin
        entry_q[sel_q] <= entry_wdata;
      end
    end
  end

  // Line data needs no reset: it is only observable behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (!rst_i && data_we) begin
      data_q[sel_q] <= mem_wdata_i;
    end
  end

  lru_is_oldest: assert property (@(posedge clk_i) disable iff (rst_i)
    ages[lru_idx] == AgeBits'(Entries - 1));

endmodule

// File: tb/tb_victim_cache_assoc.sv
// Directed bench for victim_cache_assoc with a recency-queue reference model.
module tb_victim_cache_assoc;

  logic         clk, rst;
  logic         mem_read, mem_write, mem_wdirty;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata, mem_rdata;
  logic         mem_rdirty, mem_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  victim_cache_assoc dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_read_i     (mem_read),
    .mem_write_i    (mem_write),
    .mem_address_i  (mem_address),
    .mem_wdata_i    (mem_wdata),
    .mem_wdirty_i   (mem_wdirty),
    .mem_rdata_o    (mem_rdata),
    .mem_rdirty_o   (mem_rdirty),
    .mem_resp_o     (mem_resp),
    .pmem_read_o    (pmem_read),
    .pmem_write_o   (pmem_write),
    .pmem_address_o (pmem_address),
    .pmem_wdata_o   (pmem_wdata),
    .pmem_rdata_i   (pmem_rdata),
    .pmem_resp_i    (pmem_resp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: per-slot contents plus a recency queue (front = most recent, back = LRU).
  logic         m_valid [8];
  logic         m_dirty [8];
  logic [26:0]  m_line  [8];
  logic [255:0] m_data  [8];
  int           rec[$];

  // Expectations for the cycle following the next rising edge.
  logic         chk_en;
  logic         exp_resp, exp_isread, exp_rdirty, exp_pread, exp_pwrite, exp_zero;
  logic [255:0] exp_rdata, exp_pwdata;
  logic [31:0]  exp_paddr;

  // Captured DUT activity for the literal checks.
  logic [31:0]  cap_rd_addr, cap_wb_addr;
  logic [255:0] cap_rdata, cap_wb_data;
  logic         cap_rdirty;
  int           wb_cycles, pmem_cycles;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic void set_idle();
    exp_resp = 0; exp_isread = 0; exp_rdirty = 0; exp_pread = 0; exp_pwrite = 0;
    exp_zero = 0; exp_rdata = '0; exp_pwdata = '0; exp_paddr = '0;
  endfunction

  function automatic void model_reset();
    rec.delete();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_line[i] = '0; m_data[i] = '0;
      rec.push_back(i);
    end
  endfunction

  function automatic void rec_remove(int idx);
    for (int i = 0; i < rec.size(); i++) begin
      if (rec[i] == idx) begin
        rec.delete(i);
        break;
      end
    end
  endfunction

  function automatic void model_find(input logic [31:0] addr, output bit hit, output bit free,
                                     output int idx);
    hit = 0; free = 0; idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_valid[i] && m_line[i] == addr[31:5]) begin hit = 1; idx = i; end
    end
    if (!hit) begin
      for (int i = 7; i >= 0; i--) begin
        if (!m_valid[i]) begin free = 1; idx = i; end
      end
      if (!free) idx = rec[$];
    end
  endfunction

  function automatic logic [255:0] line_data(int line);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(line);
    return {8{w}};
  endfunction

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("mem_resp", 256'(mem_resp), 256'(exp_resp));
      chk("pmem_read", 256'(pmem_read), 256'(exp_pread));
      chk("pmem_write", 256'(pmem_write), 256'(exp_pwrite));
      if (exp_resp && exp_isread) begin
        chk("mem_rdata", mem_rdata, exp_rdata);
        chk("mem_rdirty", 256'(mem_rdirty), 256'(exp_rdirty));
      end
      if (exp_pread || exp_pwrite) chk("pmem_address", 256'(pmem_address), 256'(exp_paddr));
      if (exp_pwrite) chk("pmem_wdata", pmem_wdata, exp_pwdata);
      if (exp_zero) begin
        chk("reset_rdata", mem_rdata, '0);
        chk("reset_paddr", 256'(pmem_address), '0);
        chk("reset_pwdata", pmem_wdata, '0);
      end
      if (pmem_read) cap_rd_addr = pmem_address;
      if (pmem_write) begin
        cap_wb_addr = pmem_address; cap_wb_data = pmem_wdata; wb_cycles++;
      end
      if (pmem_read || pmem_write) pmem_cycles++;
      if (mem_resp) begin cap_rdata = mem_rdata; cap_rdirty = mem_rdirty; end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1; mem_read = 0; mem_write = 0; pmem_resp = 0;
    set_idle(); exp_zero = 1;
    model_reset();
    @(negedge clk);
    rst = 0; set_idle();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [255:0] pdata, input int lat);
    bit hit, free;
    int idx;
    model_find(addr, hit, free, idx);
    @(negedge clk);
    mem_read = 1; mem_address = addr; set_idle();
    if (hit) begin
      exp_resp = 1; exp_isread = 1; exp_rdata = m_data[idx]; exp_rdirty = m_dirty[idx];
    end else begin
      exp_pread = 1; exp_paddr = addr & ~32'h1f;
      repeat (lat - 1) @(negedge clk);
      @(negedge clk);
      pmem_resp = 1; pmem_rdata = pdata; set_idle();
      exp_resp = 1; exp_isread = 1; exp_rdata = pdata; exp_rdirty = 0;
    end
    @(negedge clk);
    mem_read = 0; pmem_resp = 0; set_idle();
    if (hit) begin
      m_valid[idx] = 0; m_dirty[idx] = 0;
      rec_remove(idx); rec.push_back(idx);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] data, input logic dirty,
                          input int lat);
    bit hit, free;
    int idx;
    model_find(addr, hit, free, idx);
    @(negedge clk);
    mem_write = 1; mem_address = addr; mem_wdata = data; mem_wdirty = dirty; set_idle();
    if (!hit && !free && m_dirty[idx]) begin
      exp_pwrite = 1; exp_paddr = {m_line[idx], 5'b0}; exp_pwdata = m_data[idx];
      repeat (lat - 1) @(negedge clk);
      @(negedge clk);
      pmem_resp = 1; set_idle();
    end
    exp_resp = 1;
    @(negedge clk);
    mem_write = 0; pmem_resp = 0; set_idle();
    m_dirty[idx] = dirty | (hit & m_dirty[idx]);
    m_valid[idx] = 1; m_line[idx] = addr[31:5]; m_data[idx] = data;
    rec_remove(idx); rec.push_front(idx);
  endtask

  // Starts a write-back insert, then resets while the pmem write is still outstanding.
  task automatic do_write_abort(input logic [31:0] addr, input int wait_cycles);
    bit hit, free;
    int idx;
    model_find(addr, hit, free, idx);
    @(negedge clk);
    mem_write = 1; mem_address = addr; mem_wdata = '1; mem_wdirty = 1; set_idle();
    exp_pwrite = 1; exp_paddr = {m_line[idx], 5'b0}; exp_pwdata = m_data[idx];
    repeat (wait_cycles) @(negedge clk);
    rst = 1; mem_write = 0; set_idle(); exp_zero = 1;
    model_reset();
    @(negedge clk);
    rst = 0; set_idle();
  endtask

  initial begin
    clk = 0; rst = 1; mem_read = 0; mem_write = 0; mem_address = '0; mem_wdata = '0;
    mem_wdirty = 0; pmem_rdata = '0; pmem_resp = 0; chk_en = 0;
    cap_rd_addr = '0; cap_wb_addr = '0; cap_rdata = '0; cap_wb_data = '0; cap_rdirty = 0;
    wb_cycles = 0; pmem_cycles = 0;
    set_idle(); exp_zero = 1; model_reset();
    @(negedge clk);
    chk_en = 1;

    // Miss fills from pmem without allocating.
    do_reset();
    do_read(32'h1000, {32{8'hAA}}, 3);
    chk("t1_paddr", 256'(cap_rd_addr), 256'(32'h1000));
    chk("t1_rdata", cap_rdata, {32{8'hAA}});
    chk("t1_rdirty", 256'(cap_rdirty), 256'(0));

    // Hit returns the dirty line and releases it; a second probe misses.
    do_reset();
    do_write(32'h2000, {8{32'h5A5A_0001}}, 1, 1);
    pmem_cycles = 0;
    do_read(32'h2000, '0, 1);
    chk("t2_hit_rdata", cap_rdata, {8{32'h5A5A_0001}});
    chk("t2_hit_rdirty", 256'(cap_rdirty), 256'(1));
    chk("t2_hit_no_pmem", 256'(pmem_cycles), 256'(0));
    do_read(32'h2014, {8{32'h0BAD_F00D}}, 2);
    chk("t2_miss_paddr", 256'(cap_rd_addr), 256'(32'h2000));
    chk("t2_miss_rdirty", 256'(cap_rdirty), 256'(0));

    // Clean LRU victim is overwritten silently; line 1 is the one lost.
    do_reset();
    for (int l = 0; l < 8; l++) do_write(32'(l) << 5, line_data(l), 0, 1);
    do_write(32'h0, line_data(0), 0, 1);
    pmem_cycles = 0;
    do_write(32'h100, line_data(8), 0, 1);
    chk("t3_no_wb", 256'(pmem_cycles), 256'(0));
    do_read(32'h20, {8{32'h1234_5678}}, 1);
    chk("t3_line1_miss", 256'(cap_rd_addr), 256'(32'h20));
    do_read(32'h0, '0, 1);
    chk("t3_line0_hit", cap_rdata, {8{32'hC0DE_0000}});

    // Dirty LRU victim is written back with a slow pmem.
    do_reset();
    for (int l = 0; l < 8; l++) do_write(32'(l) << 5, line_data(l), 1, 1);
    wb_cycles = 0;
    do_write(32'h100, line_data(8), 1, 5);
    chk("t4_wb_addr", 256'(cap_wb_addr), 256'(32'h0));
    chk("t4_wb_data", cap_wb_data, {8{32'hC0DE_0000}});
    chk("t4_wb_cycles", 256'(wb_cycles), 256'(5));

    // Re-inserting a present tag updates in place and keeps it dirty.
    do_reset();
    do_write(32'h2000, {8{32'h1111_1111}}, 1, 1);
    do_write(32'h2000, {8{32'h2222_2222}}, 0, 1);
    pmem_cycles = 0;
    for (int l = 1; l < 8; l++) do_write(32'(l) << 5, line_data(l), 0, 1);
    chk("t5_no_evict", 256'(pmem_cycles), 256'(0));
    do_read(32'h2000, '0, 1);
    chk("t5_rdata", cap_rdata, {8{32'h2222_2222}});
    chk("t5_rdirty", 256'(cap_rdirty), 256'(1));

    // Reset during an outstanding write-back.
    do_reset();
    for (int l = 0; l < 8; l++) do_write(32'(l) << 5, line_data(l), 1, 1);
    do_write_abort(32'h100, 2);
    do_read(32'h20, {8{32'hFEED_BEEF}}, 1);
    chk("t6_after_rst_miss", 256'(cap_rd_addr), 256'(32'h20));
    chk("t6_after_rst_rdata", cap_rdata, {8{32'hFEED_BEEF}});

    @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
